bemf_zc_detector: RTL and testbench

- Receive side of the sensorless commutation interface.
- Samples the three back-EMF comparator outputs and detects the zero crossing on the floating phase for the current step.
- Waits the 30-degree electrical delay after each crossing, then emits a commutation pulse and the next step index.
- Takes over from the open-loop start-up sequencer in bldc_FSM through a step-load handover.

---
 rtl/bemf_zc_detector.sv | 190 +++++++++++++++++++
 tb/tb_bemf_zc_detector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bemf_zc_detector.sv
// bemf_zc_detector
// Sensorless BLDC back-EMF zero-crossing detector. Synchronizes the three
// comparator outputs, watches the floating phase of the current step for its
// zero crossing (with blanking and a consecutive-sample filter), waits the
// 30-degree delay (equal to the blank-to-crossing time), then pulses
// commutate and advances the step. Takes over from the open-loop start-up
// sequencer through load_step/step_in.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   enable       closed-loop detection enable; low forces IDLE and clears flags
//   comp[2:0]    async comparator outputs, [0]=A [1]=B [2]=C, 1 = above neutral
//   load_step    one-cycle handover pulse, captures step_in
//   step_in      step index 0..5 (6/7 load as 0)
//   commutate    one-cycle pulse: advance commutation now
//   step_out     current step index 0..5
//   step_period  cycles strictly between the last two commutate pulses
//   locked       LOCK_COUNT consecutive closed-loop commutations seen
//   fault        sticky loss-of-sync flag
module bemf_zc_detector #(
    parameter int CNT_W        = 20,
    parameter int BLANK_CYCLES = 200,
    parameter int FILTER_LEN   = 4,
    parameter int TIMEOUT      = 1000000,
    parameter int LOCK_COUNT   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       comp,
    input  logic             load_step,
    input  logic [2:0]       step_in,
    output logic             commutate,
    output logic [2:0]       step_out,
    output logic [CNT_W-1:0] step_period,
    output logic             locked,
    output logic             fault
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [FW-1:0]    FILT_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [GW-1:0]    LOCK_C     = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SEEK,
        DELAY
    } state_t;

    state_t           state, state_n;
    logic [2:0]       comp_meta, comp_sync;
    logic [CNT_W-1:0] elapsed, elapsed_n;
    logic [CNT_W-1:0] delay_cnt, delay_n;
    logic [CNT_W-1:0] period_n;
    logic [FW-1:0]    filt, filt_n;
    logic [GW-1:0]    good, good_n;
    logic [2:0]       step_n;
    logic             fault_n;
    logic             pulse;
    logic             zc_bit;
    logic             zc_level;

    // Floating phase and its post-crossing level for the current step.
    // Odd steps see a rising crossing, even steps a falling one.
    always_comb begin
        zc_level = step_out[0];
        case (step_out)
            3'd0, 3'd3: zc_bit = comp_sync[2];
            3'd1, 3'd4: zc_bit = comp_sync[1];
            default:    zc_bit = comp_sync[0];
        endcase
    end

    always_comb begin
        state_n   = state;
        elapsed_n = elapsed;
        delay_n   = delay_cnt;
        period_n  = step_period;
        filt_n    = filt;
        good_n    = good;
        step_n    = step_out;
        fault_n   = fault;
        pulse     = 1'b0;

        if (!enable) begin
            state_n   = IDLE;
            elapsed_n = '0;
            delay_n   = '0;
            filt_n    = '0;
            good_n    = '0;
            fault_n   = 1'b0;
        end else if (load_step) begin
            // Handover or re-synchronization; suppresses any confirm/pulse
            // that would otherwise happen this cycle.
            state_n   = BLANK;
            elapsed_n = '0;
            delay_n   = '0;
            filt_n    = '0;
            good_n    = '0;
            step_n    = (step_in > 3'd5) ? 3'd0 : step_in;
        end else if ((state == BLANK || state == SEEK) && elapsed >= TIMEOUT_C) begin
            state_n = IDLE;
            filt_n  = '0;
            good_n  = '0;
            fault_n = 1'b1;
        end else begin
            if (state != IDLE && elapsed != '1) begin
                elapsed_n = elapsed + 1'b1;
            end
            case (state)
                BLANK: begin
                    filt_n = '0;
                    if (elapsed >= BLANK_LAST) begin
                        state_n = SEEK;
                    end
                end
                SEEK: begin
                    if (zc_bit == zc_level) begin
                        if (filt >= FILT_LAST) begin
                            // Confirmed: the time since blanking started is
                            // the 30-degree delay to wait before commutating.
                            filt_n  = '0;
                            delay_n = elapsed;
                            state_n = DELAY;
                        end else begin
                            filt_n = filt + 1'b1;
                        end
                    end else begin
                        filt_n = '0;
                    end
                end
                DELAY: begin
                    if (delay_cnt != '0) begin
                        delay_n = delay_cnt - 1'b1;
                    end
                    // Loaded with t_zc on the confirm cycle, so reaching 1
                    // lands exactly t_zc cycles after confirmation.
                    if (delay_cnt <= CNT_W'(1)) begin
                        pulse     = 1'b1;
                        step_n    = (step_out == 3'd5) ? 3'd0 : step_out + 3'd1;
                        period_n  = elapsed;
                        delay_n   = '0;
                        elapsed_n = '0;
                        state_n   = BLANK;
                        if (good != LOCK_C) begin
                            good_n = good + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            comp_meta   <= '0;
            comp_sync   <= '0;
            state       <= IDLE;
            elapsed     <= '0;
            delay_cnt   <= '0;
            filt        <= '0;
            good        <= '0;
            step_out    <= '0;
            step_period <= '0;
            fault       <= 1'b0;
        end else begin
            comp_meta   <= comp;
            comp_sync   <= comp_meta;
            state       <= state_n;
            elapsed     <= elapsed_n;
            delay_cnt   <= delay_n;
            filt        <= filt_n;
            good        <= good_n;
            step_out    <= step_n;
            step_period <= period_n;
            fault       <= fault_n;
        end
    end

    assign commutate = pulse & ~rst;
    assign locked    = (good == LOCK_C);

endmodule

// File: tb/tb_bemf_zc_detector.sv
// tb_bemf_zc_detector
// Scoreboard bench for bemf_zc_detector with small blanking/filter/timeout
// values. Stimulus pushes expected commutate pulses and expected output
// snapshots into queues; a negedge monitor pops and compares them.
module tb_bemf_zc_detector;

    localparam int CNT_W = 20;
    localparam int BLANK = 4;
    localparam int FILT  = 3;
    localparam int TOUT  = 500;
    localparam int LOCKN = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [2:0]       comp;
    logic             load_step;
    logic [2:0]       step_in;
    logic             commutate;
    logic [2:0]       step_out;
    logic [CNT_W-1:0] step_period;
    logic             locked;
    logic             fault;

    bemf_zc_detector #(
        .CNT_W(CNT_W),
        .BLANK_CYCLES(BLANK),
        .FILTER_LEN(FILT),
        .TIMEOUT(TOUT),
        .LOCK_COUNT(LOCKN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .comp(comp),
        .load_step(load_step),
        .step_in(step_in),
        .commutate(commutate),
        .step_out(step_out),
        .step_period(step_period),
        .locked(locked),
        .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [2:0]       step;
        logic [CNT_W-1:0] period;
        logic             lk;
    } pl_t;

    typedef struct {
        int               cyc;
        logic [2:0]       step;
        logic [CNT_W-1:0] period;
        logic             lk;
        logic             flt;
    } st_t;

    pl_t pq[$];
    st_t sq[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic done = 1'b0;
    pl_t  pend;
    logic pend_v = 1'b0;

    // Bench model of the visible outputs, maintained by the stimulus.
    logic [2:0]       m_step   = 3'd0;
    logic [CNT_W-1:0] m_period = '0;
    int               m_good   = 0;
    logic             m_fault  = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        st_t s;
        pl_t p;
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            cmp("snap_commutate", int'(commutate), 0);
            cmp("snap_step_out", int'(step_out), int'(s.step));
            cmp("snap_step_period", int'(step_period), int'(s.period));
            cmp("snap_locked", int'(locked), int'(s.lk));
            cmp("snap_fault", int'(fault), int'(s.flt));
        end
        if (pend_v) begin
            cmp("post_pulse_step_out", int'(step_out), int'(pend.step));
            cmp("post_pulse_step_period", int'(step_period), int'(pend.period));
            cmp("post_pulse_locked", int'(locked), int'(pend.lk));
            pend_v = 1'b0;
        end
        if (commutate) begin
            if (pq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got commutate=1 expected 0 (cycle %0d)", cyc);
            end else begin
                p = pq.pop_front();
                cmp("pulse_cycle", cyc, p.cyc);
                pend   = p;
                pend_v = 1'b1;
            end
        end else if (pq.size() > 0 && cyc > pq[0].cyc) begin
            p = pq.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_pulse: got none expected commutate at cycle %0d (now %0d)", p.cyc, cyc);
        end
        if (done) begin
            cmp("queues_drained", pq.size() + sq.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int ph(input logic [2:0] s);
        case (s)
            3'd0, 3'd3: return 2;
            3'd1, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic stat();
        st_t e;
        e.cyc    = cyc;
        e.step   = m_step;
        e.period = m_period;
        e.lk     = (m_good == LOCKN);
        e.flt    = m_fault;
        sq.push_back(e);
    endtask

    task automatic do_load(input logic [2:0] v, input logic [2:0] expv);
        step_in   = v;
        load_step = 1'b1;
        tick();
        load_step = 1'b0;
        m_step    = expv;
        m_good    = 0;
    endtask

    // Called on the first BLANK cycle (elapsed 0). pat holds the absolute
    // floating-phase levels applied from elapsed ex onward (last one held);
    // ec is the hand-computed confirm elapsed, so the pulse lands at 2*ec.
    task automatic run_step(input logic [2:0] s, input int ex, input int ec,
                            input logic [7:0] pat, input int plen,
                            input bit bpulse, input bit intercept);
        int   st;
        int   p;
        logic l;
        pl_t  e;
        st = cyc;
        p  = ph(s);
        l  = s[0];
        comp[p] = bpulse ? l : ~l;
        e.cyc    = st + 2 * ec;
        e.step   = (s == 3'd5) ? 3'd0 : s + 3'd1;
        e.period = CNT_W'(2 * ec);
        if (!intercept) begin
            m_good = (m_good < LOCKN) ? m_good + 1 : LOCKN;
            e.lk   = (m_good == LOCKN);
            pq.push_back(e);
        end
        if (bpulse) begin
            wait_until(st + 3);
            comp[p] = ~l;
        end
        for (int i = 0; i < plen; i++) begin
            wait_until(st + ex + i);
            comp[p] = pat[i];
        end
        if (intercept) begin
            wait_until(st + 2 * ec);
        end else begin
            wait_until(st + 2 * ec + 1);
            m_step   = e.step;
            m_period = e.period;
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        load_step = 1'b0;
        comp      = 3'b000;
        step_in   = 3'd0;
        tick();
        tick();
        tick();
        stat();

        // Enabled but never loaded: stays idle whatever the comparators do.
        rst    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            comp = 3'(i);
            if (i % 20 == 19) stat();
            tick();
        end

        // Load step 0, falling crossing on C at elapsed 20 -> t_zc 24.
        comp = 3'b101;
        tick();
        tick();
        tick();
        do_load(3'd0, 3'd0);
        stat();
        run_step(3'd0, 20, 24, 8'b0000_0000, 1, 1'b0, 1'b0);

        // Step 1: blanking-window pulse ignored, glitch 1,1,0,1,1,1 -> t_zc 27.
        run_step(3'd1, 20, 27, 8'b0011_1011, 6, 1'b1, 1'b0);
        stat();

        // Load step 4, twelve crossings with wrap; locked on the 12th.
        do_load(3'd4, 3'd4);
        stat();
        for (int i = 0; i < LOCKN; i++) begin
            run_step(m_step, 10 + i, 14 + i, {7'b0, m_step[0]}, 1, 1'b0, 1'b0);
        end
        stat();

        // load_step with step_in=3 on the commutate cycle: no pulse.
        run_step(m_step, 10, 14, {7'b0, m_step[0]}, 1, 1'b0, 1'b1);
        stat();
        do_load(3'd3, 3'd3);
        stat();
        run_step(3'd3, 10, 14, 8'b0000_0001, 1, 1'b0, 1'b0);

        // Timeout: load 7 (loads as 0), C held at its pre-crossing level.
        begin
            int st;
            comp[2] = 1'b1;
            do_load(3'd7, 3'd0);
            st = cyc;
            stat();
            wait_until(st + TOUT);
            stat();
            tick();
            m_fault = 1'b1;
            stat();
            comp[2] = 1'b0;
            repeat (60) tick();
            stat();
            enable = 1'b0;
            tick();
            m_fault = 1'b0;
            stat();
            enable = 1'b1;
            tick();
            stat();
        end

        repeat (5) tick();
        done = 1'b1;
    end

endmodule
